// File: rtl/eight_to_thirty_two_pkg.sv
// Shared types and sizing for the byte-to-word deserializer.
package eight_to_thirty_two_pkg;

  localparam int BYTE_W      = 8;
  localparam int WORD_W      = 32;
  localparam int NUM_BYTES   = WORD_W / BYTE_W;
  localparam int GAP_W       = 4;
  localparam int TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT1 = 2'd1,
    GOT2 = 2'd2,
    GOT3 = 2'd3
  } state_e;

endpackage

// File: rtl/gap_timer.sv
// Counts consecutive enabled cycles; pulses expire_o on the cycle the count would reach LIMIT.
module gap_timer #(
  parameter int          W     = 4,
  parameter logic [W-1:0] LIMIT = 4'd4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && !clr_i && (cnt_q == LIMIT - W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) cnt_d = '0;
    else if (en_i)         cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/eight_to_thirty_two.sv
// Assembles an MSB-first byte stream into 32-bit words, aborting partial words on a gap timeout.
module eight_to_thirty_two
  import eight_to_thirty_two_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              div_8_clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              word_valid,
  output logic              frame_err
);

  localparam int HOLD_N = NUM_BYTES - 1;

  state_e                           state_q, state_d;
  logic [HOLD_N-1:0][BYTE_W-1:0]    held_q, held_d;
  logic [WORD_W-1:0]                dout_q, dout_d;
  logic                             wv_q, wv_d;
  logic                             fe_q, fe_d;
  logic                             gap_clr, gap_en, expire;

  // Gap timing only runs while a partial word is held and no byte arrives.
  assign gap_clr = rx_valid || (state_q == IDLE);
  assign gap_en  = !gap_clr;

  gap_timer #(
    .W     (GAP_W),
    .LIMIT (GAP_W'(TIMEOUT))
  ) u_gap (
    .clk      (div_8_clk),
    .rst_n    (rst_n),
    .clr_i    (gap_clr),
    .en_i     (gap_en),
    .expire_o (expire)
  );

  // Lane i captures in the state holding (HOLD_N-1-i) bytes; lane HOLD_N-1 is the MSB.
  for (genvar i = 0; i < HOLD_N; i++) begin : g_lane
    localparam logic [1:0] LANE_ST = 2'(HOLD_N - 1 - i);
    logic cap;
    assign cap       = rx_valid && (state_q == state_e'(LANE_ST));
    assign held_d[i] = expire ? '0 : (cap ? data_in : held_q[i]);
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    wv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      IDLE: if (rx_valid) state_d = GOT1;
      GOT1: begin
        if (rx_valid)    state_d = GOT2;
        else if (expire) begin state_d = IDLE; fe_d = 1'b1; end
      end
      GOT2: begin
        if (rx_valid)    state_d = GOT3;
        else if (expire) begin state_d = IDLE; fe_d = 1'b1; end
      end
      GOT3: begin
        if (rx_valid) begin
          state_d = IDLE;
          wv_d    = 1'b1;
          dout_d  = {held_q, data_in};
        end else if (expire) begin
          state_d = IDLE;
          fe_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge div_8_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      held_q  <= '0;
      dout_q  <= '0;
      wv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      dout_q  <= dout_d;
      wv_q    <= wv_d;
      fe_q    <= fe_d;
    end
  end

  assign data_out   = dout_q;
  assign word_valid = wv_q;
  assign frame_err  = fe_q;

endmodule

// File: tb/tb_eight_to_thirty_two.sv
// Scoreboard bench: driver models the byte stream as a queue of partial bytes, monitor checks every cycle.
module tb_eight_to_thirty_two;

  localparam int TO = 4;

  logic        div_8_clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  data_in;
  logic [31:0] data_out;
  logic        word_valid;
  logic        frame_err;

  eight_to_thirty_two #(.TIMEOUT(TO)) dut (
    .div_8_clk  (div_8_clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .data_in    (data_in),
    .data_out   (data_out),
    .word_valid (word_valid),
    .frame_err  (frame_err)
  );

  initial div_8_clk = 1'b0;
  always #5 div_8_clk = ~div_8_clk;

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  part[$];
  int          gap;
  int          cyc;
  int          n_chk;
  int          n_pass;
  logic [31:0] exp_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // One sample cycle: model reacts to what the DUT will sample at the next rising edge.
  task automatic drive(input bit v, input logic [7:0] d);
    @(negedge div_8_clk);
    rx_valid = v;
    data_in  = v ? d : 8'($urandom);
    if (v) begin
      part.push_back(d);
      gap = 0;
      if (part.size() == 4) begin
        exp_q.push_back('{cyc + 1, 1'b0, {part[0], part[1], part[2], part[3]}});
        part.delete();
      end
    end else if (part.size() != 0) begin
      gap++;
      if (gap == TO) begin
        exp_q.push_back('{cyc + 1, 1'b1, 32'h0});
        part.delete();
        gap = 0;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int idle_between);
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, w[31-8*b -: 8]);
      if (b < 3) repeat (idle_between) drive(1'b0, 8'h00);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  // Monitor: compares every cycle against the head of the expectation queue.
  initial begin
    exp_t e;
    bit   ewv, efe;
    forever begin
      @(posedge div_8_clk);
      cyc++;
      #1;
      if (!rst_n) begin
        chk("reset_data_out", data_out, 32'h0);
        chk("reset_pulses", {30'h0, word_valid, frame_err}, 32'h0);
        exp_q.delete();
        exp_dout = 32'h0;
      end else begin
        ewv = 1'b0;
        efe = 1'b0;
        while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          chk("missed_event_cycle", 32'(e.cyc), 32'(cyc));
        end
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          if (e.err) efe = 1'b1;
          else begin
            ewv      = 1'b1;
            exp_dout = e.word;
          end
        end
        chk("word_valid", {31'h0, word_valid}, {31'h0, ewv});
        chk("frame_err", {31'h0, frame_err}, {31'h0, efe});
        chk("data_out", data_out, exp_dout);
      end
    end
  end

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    cyc      = 0;
    gap      = 0;
    exp_dout = 32'h0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(negedge div_8_clk);
    rst_n = 1'b1;

    send_word(32'hDEADBEEF, 0);
    idle(2);
    send_word(32'h01020304, 0);
    send_word(32'h05060708, 0);
    idle(2);
    send_word(32'h11223344, TO - 1);
    idle(2);
    drive(1'b1, 8'hAA);
    drive(1'b1, 8'hBB);
    idle(TO);
    send_word(32'h01020304, 0);
    idle(1);

    // Three bytes then reset: partial word must vanish without a pulse.
    drive(1'b1, 8'h12);
    drive(1'b1, 8'h34);
    drive(1'b1, 8'h56);
    @(negedge div_8_clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    part.delete();
    gap = 0;
    repeat (2) @(negedge div_8_clk);
    rst_n = 1'b1;
    send_word(32'hCAFEBABE, 0);

    idle(100);

    // A byte on the last tolerated gap cycle, then a timeout from GOT3.
    drive(1'b1, 8'h9A);
    idle(TO - 1);
    drive(1'b1, 8'h9B);
    drive(1'b1, 8'h9C);
    idle(TO);
    drive(1'b1, 8'h77);
    drive(1'b1, 8'h66);
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h44);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 9) idle(int'($urandom_range(2, 6)));
      else        drive(r < 6, 8'($urandom));
    end

    idle(TO + 4);
    chk("pending_expectations", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/eight_to_thirty_two.md
EIGHT_TO_THIRTY_TWO -- requirements
Module: eight_to_thirty_two

Interface
REQ-001 Parameters SHALL be, one per line:
  - TIMEOUT, 4, consecutive no-byte cycles inside a partial word before that word is aborted; legal range 1..15.
REQ-002 Ports SHALL be, one per line:
  - div_8_clk  input  1  sole clock; all state changes on its rising edge.
  - rst_n  input  1  reset, asynchronous and active-low.
  - rx_valid  input  1  data_in carries a valid byte this cycle.
  - data_in  input  8  byte stream from the upstream 32-to-8 serializer stage, most-significant byte first.
  - data_out  output  32  last completely assembled word.
  - word_valid  output  1  one-cycle pulse: data_out was updated with a new word.
  - frame_err  output  1  one-cycle pulse: a partial word was aborted on gap timeout.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have four states:
  - IDLE: 0 bytes held.
  - GOT1, GOT2, GOT3: 1, 2 or 3 bytes held.
REQ-005 The FSM SHALL advance IDLE->GOT1->GOT2->GOT3 on each cycle with rx_valid=1.
REQ-006 With rx_valid=0, the FSM SHALL hold its state, except on timeout (REQ-011).
REQ-007 Bytes accepted in IDLE, GOT1 and GOT2 SHALL be stored into holding bits [31:24], [23:16] and [15:8] respectively.
REQ-008 When rx_valid=1 in GOT3, the block SHALL do all of the following on the next edge:
  - register data_out <= {held[31:8], data_in};
  - assert word_valid for exactly one cycle;
  - return the FSM to IDLE.
REQ-009 Latency SHALL be one cycle: word_valid is high in the cycle immediately after the 4th byte is sampled.
REQ-010 Back-to-back words SHALL be supported: 8 consecutive rx_valid cycles produce 2 word_valid pulses, 4 cycles apart, with no lost byte.
REQ-011 A gap counter SHALL behave as follows:
  - it counts consecutive rx_valid=0 cycles while in GOT1..GOT3;
  - it clears on any rx_valid=1 and whenever the FSM is in IDLE;
  - on the cycle the count reaches TIMEOUT, the FSM SHALL go to IDLE, discard the held bytes, and pulse frame_err for one cycle.
REQ-012 On a timeout abort, data_out SHALL keep its previous value and word_valid SHALL stay 0.
REQ-013 A byte arriving in the same cycle the counter would reach TIMEOUT SHALL be accepted; no error SHALL be raised in that cycle.
REQ-014 A byte arriving in the cycle after a timeout abort SHALL be treated as byte 0 of a new word.
REQ-015 rx_valid=0 in IDLE SHALL never raise frame_err, however long it persists.
REQ-016 data_out SHALL change only on a word_valid edge and SHALL be stable at all other times.
REQ-017 word_valid and frame_err SHALL never be high in the same cycle.
REQ-018 data_in SHALL be ignored whenever rx_valid=0.
REQ-019 Illegal FSM encodings SHALL recover to IDLE on the next edge with no output pulse.

Reset
REQ-020 Asserting rst_n low SHALL asynchronously force:
  - FSM = IDLE, gap counter = 0, holding register = 0;
  - data_out = 32'h0, word_valid = 0, frame_err = 0.
REQ-021 Reset in the middle of a word SHALL discard that partial word; no output pulse SHALL be generated, during reset or after it.
REQ-022 The first rising edge after rst_n deasserts SHALL be able to accept byte 0.

Structure
REQ-023 A shared package SHALL hold:
  - the FSM state enumeration (IDLE, GOT1, GOT2, GOT3);
  - the byte width (8) and word width (32);
  - the default TIMEOUT value.
REQ-024 The gap counter SHALL be a separate sub-module, gap_timer, with these ports:
  - inputs: clock, reset, clear, count enable;
  - output: one-cycle expire pulse;
  - width: 4 bits.
REQ-025 Everything else SHALL be implemented in eight_to_thirty_two itself.

Verification
REQ-026 Single word:
  - stimulus: bytes 8'hDE, AD, BE, EF on 4 consecutive cycles;
  - response: next cycle data_out=32'hDEADBEEF and word_valid=1 for one cycle.
REQ-027 Back-to-back:
  - stimulus: 8 consecutive bytes 01..08;
  - response: word_valid pulses carrying 32'h01020304 then 32'h05060708, 4 cycles apart.
REQ-028 Tolerated gaps:
  - stimulus: bytes 8'h11, 22, 33, 44, each separated by 3 idle cycles (TIMEOUT=4);
  - response: data_out=32'h11223344, word_valid pulse, frame_err stays 0.
REQ-029 Timeout abort:
  - stimulus: bytes 8'hAA, BB, then 4 idle cycles;
  - response: frame_err pulses once, data_out unchanged, FSM in IDLE;
  - follow-up: 8'h01, 02, 03, 04 yields 32'h01020304.
REQ-030 Reset mid-word:
  - stimulus: 3 bytes, then rst_n low for 2 cycles;
  - response: all outputs 0, no pulses;
  - follow-up: 8'hCA, FE, BA, BE yields 32'hCAFEBABE.
REQ-031 Long idle:
  - stimulus: 100 cycles of rx_valid=0 starting in IDLE;
  - response: no frame_err pulse, no word_valid pulse.
